// File: rtl/stratigo_game_ctrl.sv
// Stratigo turn sequencer: setup phases, select/move/combat turns, win detection.
module stratigo_game_ctrl #(
  parameter int unsigned P1_PIECES = 10,
  parameter int unsigned P2_PIECES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [2:0] raw_x,
  input  logic [2:0] raw_y,
  input  logic [5:0] piece,
  input  logic [5:0] sel_piece,
  output logic [2:0] current_phase,
  output logic [1:0] command,
  output logic       turn,
  output logic       win_flag,
  output logic       winner,
  output logic       bad_move
);

  localparam int unsigned CW = 3;
  localparam int unsigned PW = 6;
  localparam int unsigned UW = 5;

  localparam logic [1:0]    CMD_CAPTURE = 2'b00;
  localparam logic [1:0]    CMD_DIE     = 2'b01;
  localparam logic [1:0]    CMD_TRADE   = 2'b10;
  localparam logic [1:0]    CMD_NOP     = 2'b11;
  localparam logic [UW-1:0] U_FLAG      = UW'(1);
  localparam logic [UW-1:0] U_BOMB      = UW'(2);
  localparam logic [UW-1:0] U_SPY       = UW'(3);
  localparam logic [UW-1:0] U_MINER     = UW'(5);
  localparam logic [UW-1:0] U_TEN       = UW'(7);
  localparam logic [PW-1:0] SQ_BLANK    = PW'(0);
  localparam logic [PW-1:0] SQ_WALL     = PW'(63);

  typedef enum logic [3:0] {
    S_SETUP1, S_SETUP2, S_SEL, S_SEL_CHK, S_MOV, S_MOV_CHK, S_CAP, S_CAP2, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            go_q;
  logic [CW-1:0]   src_x_q, src_x_d, src_y_q, src_y_d;
  logic [CW-1:0]   dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [UW-1:0]   att_q, att_d;
  logic            flag_q, flag_d;
  logic [2:0]      phase_q, phase_d;
  logic [1:0]      command_q, command_d;
  logic            turn_q, turn_d;
  logic            win_q, win_d;
  logic            winner_q, winner_d;
  logic            bad_q, bad_d;

  logic            event_c;
  logic            movable_c;
  logic signed [3:0] dx_c, dy_c;
  logic [3:0]      adx_c, ady_c;
  logic [4:0]      dist_c;
  logic            target_ok_c;
  logic [1:0]      cmd_c;
  logic            flag_c;

  assign event_c   = go & ~go_q;
  assign movable_c = (sel_piece[UW-1:0] >= UW'(3)) && (sel_piece[UW-1:0] <= UW'(7));

  // Manhattan distance between latched source and target squares
  assign dx_c   = $signed({1'b0, dst_x_q}) - $signed({1'b0, src_x_q});
  assign dy_c   = $signed({1'b0, dst_y_q}) - $signed({1'b0, src_y_q});
  assign adx_c  = dx_c[3] ? $unsigned(-dx_c) : $unsigned(dx_c);
  assign ady_c  = dy_c[3] ? $unsigned(-dy_c) : $unsigned(dy_c);
  assign dist_c = {1'b0, adx_c} + {1'b0, ady_c};

  assign target_ok_c = (dist_c == 5'd1) && (sel_piece != SQ_WALL) &&
                       ((sel_piece == SQ_BLANK) || (sel_piece[PW-1] != turn_q));

  // Combat resolution between the selected attacker and the target square
  always_comb begin
    cmd_c  = CMD_CAPTURE;
    flag_c = 1'b0;
    if (sel_piece == SQ_BLANK) begin
      cmd_c = CMD_CAPTURE;
    end else if (sel_piece[UW-1:0] == U_FLAG) begin
      cmd_c  = CMD_CAPTURE;
      flag_c = 1'b1;
    end else if (sel_piece[UW-1:0] == U_BOMB) begin
      cmd_c = (att_q == U_MINER) ? CMD_CAPTURE : CMD_DIE;
    end else if ((att_q == U_SPY) && (sel_piece[UW-1:0] == U_TEN)) begin
      cmd_c = CMD_CAPTURE;
    end else if (att_q > sel_piece[UW-1:0]) begin
      cmd_c = CMD_CAPTURE;
    end else if (att_q < sel_piece[UW-1:0]) begin
      cmd_c = CMD_DIE;
    end else begin
      cmd_c = CMD_TRADE;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    src_x_d   = src_x_q;
    src_y_d   = src_y_q;
    dst_x_d   = dst_x_q;
    dst_y_d   = dst_y_q;
    att_d     = att_q;
    flag_d    = flag_q;
    command_d = CMD_NOP;
    turn_d    = turn_q;
    win_d     = win_q;
    winner_d  = winner_q;
    bad_d     = 1'b0;
    phase_d   = 3'd0;
    case (state_q)
      S_SETUP1: if (piece >= PW'(P1_PIECES)) state_d = S_SETUP2;
      S_SETUP2: if (piece >= PW'(P2_PIECES)) state_d = S_SEL;
      S_SEL: begin
        if (event_c) begin
          src_x_d = raw_x;
          src_y_d = raw_y;
          state_d = S_SEL_CHK;
        end
      end
      S_SEL_CHK: begin
        if ((sel_piece[PW-1] == turn_q) && movable_c) begin
          att_d   = sel_piece[UW-1:0];
          state_d = S_MOV;
        end else begin
          bad_d   = 1'b1;
          state_d = S_SEL;
        end
      end
      S_MOV: begin
        if (event_c) begin
          dst_x_d = raw_x;
          dst_y_d = raw_y;
          state_d = S_MOV_CHK;
        end
      end
      S_MOV_CHK: begin
        if (target_ok_c) begin
          command_d = cmd_c;
          flag_d    = flag_c;
          state_d   = S_CAP;
        end else begin
          bad_d   = 1'b1;
          state_d = S_SEL;
        end
      end
      S_CAP: begin
        command_d = command_q;
        state_d   = S_CAP2;
      end
      S_CAP2: begin
        if (flag_q) begin
          win_d    = 1'b1;
          winner_d = turn_q;
          state_d  = S_DONE;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_SEL;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_SETUP1;
    endcase
    case (state_d)
      S_SETUP1:  phase_d = 3'd0;
      S_SETUP2:  phase_d = 3'd1;
      S_SEL:     phase_d = 3'd2;
      S_SEL_CHK: phase_d = 3'd2;
      S_MOV:     phase_d = 3'd3;
      S_MOV_CHK: phase_d = 3'd6;
      S_CAP:     phase_d = 3'd4;
      S_CAP2:    phase_d = 3'd5;
      S_DONE:    phase_d = 3'd7;
      default:   phase_d = 3'd0;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_SETUP1;
      go_q      <= 1'b0;
      src_x_q   <= '0;
      src_y_q   <= '0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      att_q     <= '0;
      flag_q    <= 1'b0;
      phase_q   <= 3'd0;
      command_q <= CMD_NOP;
      turn_q    <= 1'b0;
      win_q     <= 1'b0;
      winner_q  <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_q      <= go;
      src_x_q   <= src_x_d;
      src_y_q   <= src_y_d;
      dst_x_q   <= dst_x_d;
      dst_y_q   <= dst_y_d;
      att_q     <= att_d;
      flag_q    <= flag_d;
      phase_q   <= phase_d;
      command_q <= command_d;
      turn_q    <= turn_d;
      win_q     <= win_d;
      winner_q  <= winner_d;
      bad_q     <= bad_d;
    end
  end

  assign current_phase = phase_q;
  assign command       = command_q;
  assign turn          = turn_q;
  assign win_flag      = win_q;
  assign winner        = winner_q;
  assign bad_move      = bad_q;

endmodule

// File: tb/tb_stratigo_game_ctrl.sv
// Bench for stratigo_game_ctrl: board datapath stand-in plus rule-level game model.
module tb_stratigo_game_ctrl;

  localparam int unsigned P1 = 10;
  localparam int unsigned P2 = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic [2:0] raw_x = 3'd0;
  logic [2:0] raw_y = 3'd0;
  logic [5:0] piece = 6'd0;
  logic [5:0] sel_piece;
  logic [2:0] current_phase;
  logic [1:0] command;
  logic       turn, win_flag, winner, bad_move;

  stratigo_game_ctrl #(.P1_PIECES(P1), .P2_PIECES(P2)) dut (
    .clk(clk), .reset(reset), .go(go), .raw_x(raw_x), .raw_y(raw_y),
    .piece(piece), .sel_piece(sel_piece), .current_phase(current_phase),
    .command(command), .turn(turn), .win_flag(win_flag), .winner(winner),
    .bad_move(bad_move)
  );

  always #5 clk = ~clk;

  // Board memory standing in for the datapath: one-cycle read at the cursor
  logic [5:0] board [8][8];
  always @(posedge clk) sel_piece <= board[raw_y][raw_x];

  int n_cmp = 0;
  int n_err = 0;

  // Game model state
  int m_turn, m_sx, m_sy, m_att;
  bit m_win;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit is_movable(input int v);
    return ((v & 31) >= 3) && ((v & 31) <= 7);
  endfunction

  // Combat outcome: 0 capture, 1 die, 2 trade
  function automatic int combat(input int att, input int def, output bit flag);
    int a, d;
    a = att & 31;
    d = def & 31;
    flag = 1'b0;
    if (def == 0) return 0;
    if (d == 1) begin flag = 1'b1; return 0; end
    if (d == 2) return (a == 5) ? 0 : 1;
    if (a == 3 && d == 7) return 0;
    if (a > d) return 0;
    if (a < d) return 1;
    return 2;
  endfunction

  task automatic clear_board();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) board[y][x] = 6'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; piece = 6'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_phase", int'(current_phase), 0);
    check("rst_command", int'(command), 3);
    check("rst_turn", int'(turn), 0);
    check("rst_win", int'(win_flag), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_bad", int'(bad_move), 0);
    reset = 1'b0;
    m_turn = 0;
    m_win = 1'b0;
  endtask

  task automatic do_setup();
    piece = 6'(P1 - 1); go = 1'b1;
    @(negedge clk);
    check("setup1_hold", int'(current_phase), 0);
    go = 1'b0; piece = 6'(P1);
    @(negedge clk);
    check("setup2_enter", int'(current_phase), 1);
    check("setup2_cmd", int'(command), 3);
    piece = 6'(P2 - 1); go = 1'b1;
    @(negedge clk);
    check("setup2_hold", int'(current_phase), 1);
    go = 1'b0; piece = 6'(P2);
    @(negedge clk);
    check("sel_enter", int'(current_phase), 2);
    check("sel_enter_cmd", int'(command), 3);
  endtask

  task automatic new_game();
    do_reset();
    do_setup();
  endtask

  task automatic do_select(input int x, input int y, output bit ok);
    int v;
    v = int'(board[y][x]);
    ok = is_movable(v) && (((v >> 5) & 1) == m_turn);
    raw_x = 3'(x); raw_y = 3'(y); go = 1'b1;
    @(negedge clk);
    check("selchk_phase", int'(current_phase), 2);
    @(negedge clk);
    check("sel_result_phase", int'(current_phase), ok ? 3 : 2);
    check("sel_bad", int'(bad_move), ok ? 0 : 1);
    check("sel_turn", int'(turn), m_turn);
    go = 1'b0;
    @(negedge clk);
    check("sel_bad_end", int'(bad_move), 0);
    if (ok) begin
      m_sx = x; m_sy = y; m_att = v;
    end
  endtask

  task automatic do_move(input int x, input int y);
    int t, cmd;
    bit legal, flag;
    t = int'(board[y][x]);
    legal = (iabs(x - m_sx) + iabs(y - m_sy) == 1) && (t != 63) &&
            ((t == 0) || (((t >> 5) & 1) != m_turn));
    cmd = combat(m_att, t, flag);
    raw_x = 3'(x); raw_y = 3'(y); go = 1'b1;
    @(negedge clk);
    check("movchk_phase", int'(current_phase), 6);
    check("movchk_cmd", int'(command), 3);
    go = 1'b0;
    @(negedge clk);
    if (legal) begin
      check("cap_phase", int'(current_phase), 4);
      check("cap_cmd", int'(command), cmd);
      check("cap_bad", int'(bad_move), 0);
      @(negedge clk);
      check("cap2_phase", int'(current_phase), 5);
      check("cap2_cmd", int'(command), cmd);
      @(negedge clk);
      check("post_cmd", int'(command), 3);
      if (flag) begin
        m_win = 1'b1;
        check("win_phase", int'(current_phase), 7);
        check("win_flag", int'(win_flag), 1);
        check("winner", int'(winner), m_turn);
      end else begin
        m_turn ^= 1;
        check("next_phase", int'(current_phase), 2);
        check("next_turn", int'(turn), m_turn);
        check("nowin", int'(win_flag), 0);
      end
      case (cmd)
        0: begin board[y][x] = 6'(m_att); board[m_sy][m_sx] = 6'd0; end
        1: board[m_sy][m_sx] = 6'd0;
        default: begin board[y][x] = 6'd0; board[m_sy][m_sx] = 6'd0; end
      endcase
    end else begin
      check("badmov_phase", int'(current_phase), 2);
      check("badmov_bad", int'(bad_move), 1);
      check("badmov_cmd", int'(command), 3);
      check("badmov_turn", int'(turn), m_turn);
      @(negedge clk);
      check("badmov_bad_end", int'(bad_move), 0);
    end
  endtask

  // One red attack from (3,3) onto (4,3)
  task automatic fight(input logic [5:0] att, input logic [5:0] def);
    bit ok;
    clear_board();
    board[3][3] = att;
    board[3][4] = def;
    new_game();
    do_select(3, 3, ok);
    check("fight_sel_ok", int'(ok), 1);
    if (ok) do_move(4, 3);
  endtask

  initial begin
    bit ok;
    int sx, sy, tx, ty;
    clear_board();

    // Basic move to a blank square
    board[2][1] = 6'b000100;
    new_game();
    do_select(1, 2, ok);
    do_move(2, 2);
    check("turn_after_move", int'(turn), 1);

    // Combat outcomes
    fight(6'b000101, 6'b100010);
    fight(6'b000100, 6'b100010);
    fight(6'b000011, 6'b100111);
    fight(6'b000110, 6'b100110);

    // Rejected selections and targets
    clear_board();
    board[3][3] = 6'b000110;
    board[0][0] = 6'b100100;
    board[0][1] = 6'b000010;
    board[3][4] = 6'b111111;
    board[2][3] = 6'b000101;
    new_game();
    do_select(0, 0, ok);
    do_select(1, 0, ok);
    do_select(3, 3, ok); do_move(4, 4);
    do_select(3, 3, ok); do_move(4, 3);
    do_select(3, 3, ok); do_move(3, 2);
    check("illegal_turn", int'(turn), 0);

    // Blue captures the red flag, then go edges are ignored
    clear_board();
    board[7][0] = 6'b000100;
    board[3][3] = 6'b100100;
    board[3][4] = 6'b000001;
    new_game();
    do_select(0, 7, ok); do_move(1, 7);
    do_select(3, 3, ok); do_move(4, 3);
    check("flag_win", int'(m_win), 1);
    for (int i = 0; i < 3; i++) begin
      go = 1'b1; @(negedge clk);
      go = 1'b0; @(negedge clk);
      check("done_hold_phase", int'(current_phase), 7);
      check("done_hold_win", int'(win_flag), 1);
      check("done_hold_winner", int'(winner), 1);
    end

    // Reset during capture
    clear_board();
    board[1][1] = 6'b000100;
    board[5][5] = 6'b100101;
    new_game();
    do_select(1, 1, ok); do_move(1, 2);
    do_select(5, 5, ok);
    raw_x = 3'd5; raw_y = 3'd6; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("abort_cap_phase", int'(current_phase), 4);
    reset = 1'b1;
    @(negedge clk);
    check("abort_phase", int'(current_phase), 0);
    check("abort_cmd", int'(command), 3);
    check("abort_turn", int'(turn), 0);
    check("abort_win", int'(win_flag), 0);
    reset = 1'b0;

    // Randomized games against the model
    for (int g = 0; g < 6; g++) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) begin
          int r;
          r = int'($urandom_range(0, 9));
          if (r < 4) board[y][x] = 6'd0;
          else if (r == 4) board[y][x] = 6'd63;
          else board[y][x] = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 7))};
        end
      new_game();
      for (int k = 0; k < 40 && !m_win; k++) begin
        sx = int'($urandom_range(0, 7));
        sy = int'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) begin
          for (int n = 0; n < 30; n++) begin
            if (is_movable(int'(board[sy][sx])) &&
                (int'(board[sy][sx][5]) == m_turn)) break;
            sx = int'($urandom_range(0, 7));
            sy = int'($urandom_range(0, 7));
          end
        end
        do_select(sx, sy, ok);
        if (ok) begin
          if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
              0: begin tx = (sx + 1) & 7; ty = sy; end
              1: begin tx = (sx + 7) & 7; ty = sy; end
              2: begin tx = sx; ty = (sy + 1) & 7; end
              default: begin tx = sx; ty = (sy + 7) & 7; end
            endcase
          end else begin
            tx = int'($urandom_range(0, 7));
            ty = int'($urandom_range(0, 7));
          end
          do_move(tx, ty);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
